// File: rtl/bnn_vad_pkg.sv
// bnn_vad_pkg: FSM state encoding and parameter derivations shared by the VAD core.
package bnn_vad_pkg;

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_FC, S_CMP, S_OUT} state_t;

    function automatic int f_n_win(input int fl, input int ks, input int st);
        return (fl - ks) / st + 1;
    endfunction

    function automatic int f_sw(input int n_act);
        return $clog2(n_act + 1);
    endfunction

    function automatic int f_clsw(input int n_cls);
        return (n_cls > 1) ? $clog2(n_cls) : 1;
    endfunction

endpackage

// File: rtl/bnn_vad_core_popcount.sv
// popcount: combinational count of set bits in a W-bit vector.
module popcount #(
    parameter int W = 12,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_bits,
    output logic [CW-1:0] o_cnt
);

    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < W; i++)
            o_cnt = o_cnt + CW'(i_bits[i]);
    end

endmodule

// File: rtl/bnn_vad_core.sv
// bnn_vad_core: binary conv + binary FC voice-activity classifier, one frame at a time.
// Activation of channel c, window w sits at bit c*N_WIN+w of the vector matched against fc_w.
module bnn_vad_core
    import bnn_vad_pkg::*;
#(
    parameter int DW        = 16,
    parameter int FRAME_LEN = 20,
    parameter int KSIZE     = 5,
    parameter int STRIDE    = 5,
    parameter int N_CH      = 3,
    parameter int N_CLS     = 2,
    localparam int N_WIN    = f_n_win(FRAME_LEN, KSIZE, STRIDE),
    localparam int NA       = N_CH * N_WIN,
    localparam int SW       = f_sw(NA),
    localparam int CLSW     = f_clsw(N_CLS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_vld,
    output logic                    frame_rdy,
    input  logic [DW*FRAME_LEN-1:0] frame_data,
    input  logic [N_CH*KSIZE-1:0]   conv_w,
    input  logic [N_CLS*NA-1:0]     fc_w,
    input  logic [SW-1:0]           margin,
    output logic                    result_vld,
    input  logic                    result_rdy,
    output logic [CLSW-1:0]         result,
    output logic [SW-1:0]           best_score,
    output logic [15:0]             frame_cnt
);

    localparam int SUMW = DW + $clog2(KSIZE);
    localparam int CW   = $clog2((N_WIN > N_CLS ? N_WIN : N_CLS) + 1);

    state_t                  r_state, w_next;
    logic [DW*FRAME_LEN-1:0] r_frame;
    logic [NA-1:0]           r_act;
    logic [CW-1:0]           r_cnt;
    logic [SW-1:0]           r_score [N_CLS];
    logic [CLSW-1:0]         r_result;
    logic [SW-1:0]           r_best;
    logic [15:0]             r_frame_cnt;
    logic [DW-1:0]           w_smp [KSIZE];
    logic signed [SUMW-1:0]  w_sum [N_CH];
    logic [NA-1:0]           w_fc_sel, w_xnor;
    logic [SW-1:0]           w_pop, w_best, w_second;
    logic [CLSW-1:0]         w_idx;
    logic                    w_conv_last, w_fc_last;

    assign w_conv_last = r_cnt == CW'(N_WIN - 1);
    assign w_fc_last   = r_cnt == CW'(N_CLS - 1);
    assign w_xnor      = ~(r_act ^ w_fc_sel);
    assign result      = r_result;
    assign best_score  = r_best;
    assign frame_cnt   = r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = frame_vld ? S_CONV : S_IDLE;
            S_CONV:  w_next = w_conv_last ? S_FC : S_CONV;
            S_FC:    w_next = w_fc_last ? S_CMP : S_FC;
            S_CMP:   w_next = S_OUT;
            S_OUT:   w_next = result_rdy ? S_IDLE : S_OUT;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        frame_rdy  = r_state == S_IDLE;
        result_vld = r_state == S_OUT;
    end

    // Window selected by r_cnt, then every channel sums its signed taps in parallel.
    always_comb begin
        for (int k = 0; k < KSIZE; k++) begin
            w_smp[k] = '0;
            for (int w = 0; w < N_WIN; w++)
                if (r_cnt == CW'(w)) w_smp[k] = r_frame[(w*STRIDE+k)*DW +: DW];
        end
        for (int c = 0; c < N_CH; c++) begin
            w_sum[c] = '0;
            for (int k = 0; k < KSIZE; k++)
                w_sum[c] = conv_w[c*KSIZE+k] ? w_sum[c] + SUMW'($signed(w_smp[k]))
                                             : w_sum[c] - SUMW'($signed(w_smp[k]));
        end
    end

    // Strict '>' keeps the lowest index on ties; second is the best of the rest.
    always_comb begin
        w_fc_sel = '0;
        for (int j = 0; j < N_CLS; j++)
            if (r_cnt == CW'(j)) w_fc_sel = fc_w[j*NA +: NA];
        w_best   = r_score[0];
        w_second = '0;
        w_idx    = '0;
        for (int j = 1; j < N_CLS; j++)
            if (r_score[j] > w_best) begin
                w_second = w_best;
                w_best   = r_score[j];
                w_idx    = CLSW'(j);
            end else if (r_score[j] > w_second) begin
                w_second = r_score[j];
            end
    end

    popcount #(.W(NA)) u_popcount (
        .i_bits (w_xnor),
        .o_cnt  (w_pop)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_frame     <= '0;
            r_act       <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_best      <= '0;
            r_frame_cnt <= '0;
            for (int j = 0; j < N_CLS; j++) r_score[j] <= '0;
        end else begin
            if (r_state == S_IDLE && frame_vld) r_frame <= frame_data;
            r_cnt <= ((r_state == S_CONV && !w_conv_last) || (r_state == S_FC && !w_fc_last)) ? r_cnt + 1'b1 : '0;
            if (r_state == S_CONV)
                for (int c = 0; c < N_CH; c++)
                    for (int w = 0; w < N_WIN; w++)
                        if (r_cnt == CW'(w)) r_act[c*N_WIN+w] <= ~w_sum[c][SUMW-1];
            if (r_state == S_FC)
                for (int j = 0; j < N_CLS; j++)
                    if (r_cnt == CW'(j)) r_score[j] <= w_pop;
            if (r_state == S_CMP) begin
                r_best <= w_best;
                if (w_best - w_second >= margin) r_result <= w_idx;
            end
            if (r_state == S_OUT && result_rdy) r_frame_cnt <= r_frame_cnt + 16'd1;
        end

endmodule

// File: tb/tb_bnn_vad_core.sv
// tb_bnn_vad_core: directed frames against an arithmetic model of the classifier, checked every cycle.
module tb_bnn_vad_core;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         frame_vld = 1'b0;
    logic         frame_rdy;
    logic [319:0] frame_data = '0;
    logic [14:0]  conv_w = '0;
    logic [23:0]  fc_w = '0;
    logic [3:0]   margin = '0;
    logic         result_vld;
    logic         result_rdy = 1'b0;
    logic [0:0]   result;
    logic [3:0]   best_score;
    logic [15:0]  frame_cnt;

    int n_chk = 0, n_err = 0;
    int exp_rdy = 1, exp_vld = 0, exp_result = 0, exp_best = 0, exp_cnt = 0;
    int smp [20];
    int last_max_sum;

    bnn_vad_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_vld  (frame_vld),
        .frame_rdy  (frame_rdy),
        .frame_data (frame_data),
        .conv_w     (conv_w),
        .fc_w       (fc_w),
        .margin     (margin),
        .result_vld (result_vld),
        .result_rdy (result_rdy),
        .result     (result),
        .best_score (best_score),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int a, input int e);
        n_chk++;
        if (a != e) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        chk("frame_rdy", int'(frame_rdy), exp_rdy);
        chk("result_vld", int'(result_vld), exp_vld);
        chk("result", int'(result), exp_result);
        chk("best_score", int'(best_score), exp_best);
        chk("frame_cnt", int'(frame_cnt), exp_cnt);
    end

    function automatic void model(input int s[20], input logic [14:0] cw, input logic [23:0] fw,
                                  input int mg, input int prev, output int res, output int best, output int maxsum);
        bit act [12];
        int sc [2];
        int bi, sec;
        maxsum = -1000000;
        for (int c = 0; c < 3; c++)
            for (int w = 0; w < 4; w++) begin
                int sum = 0;
                for (int k = 0; k < 5; k++) sum += cw[c*5+k] ? s[w*5+k] : -s[w*5+k];
                if (sum > maxsum) maxsum = sum;
                act[c*4+w] = (sum >= 0);
            end
        for (int j = 0; j < 2; j++) begin
            sc[j] = 0;
            for (int i = 0; i < 12; i++) if (act[i] == fw[j*12+i]) sc[j]++;
        end
        bi = 0;
        for (int j = 0; j < 2; j++) if (sc[j] > sc[bi]) bi = j;
        sec = 0;
        for (int j = 0; j < 2; j++) if (j != bi && sc[j] > sec) sec = sc[j];
        best = sc[bi];
        res = (best - sec >= mg) ? bi : prev;
    endfunction

    task automatic run(input logic [14:0] cw, input logic [23:0] fw, input int mg, input int hold,
                       input bit noisy, input int rst_at, input int pin_res, input int pin_best);
        int er, eb, ms;
        model(smp, cw, fw, mg, exp_result, er, eb, ms);
        last_max_sum = ms;
        for (int i = 0; i < 20; i++) frame_data[i*16 +: 16] = 16'(smp[i]);
        conv_w = cw;
        fc_w = fw;
        margin = 4'(mg);
        frame_vld = 1'b1;
        @(posedge clk); #1;
        frame_vld = 1'b0;
        exp_rdy = 0;
        if (noisy) begin
            frame_vld = 1'b1;
            for (int i = 0; i < 20; i++) frame_data[i*16 +: 16] = 16'h0001;
        end
        for (int cyc = 2; cyc <= 8; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 4) frame_vld = 1'b0;
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                exp_rdy = 1; exp_vld = 0; exp_result = 0; exp_best = 0; exp_cnt = 0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            if (cyc == 7) chk("vld_cycle7", int'(result_vld), 0);
        end
        exp_vld = 1;
        exp_result = er;
        exp_best = eb;
        chk("vld_cycle8", int'(result_vld), 1);
        if (pin_res >= 0) chk("pin_result", int'(result), pin_res);
        if (pin_best >= 0) chk("pin_best", int'(best_score), pin_best);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
        end
        result_rdy = 1'b1;
        @(posedge clk); #1;
        result_rdy = 1'b0;
        exp_vld = 0;
        exp_rdy = 1;
        exp_cnt = (exp_cnt + 1) & 16'hFFFF;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) smp[i] = 1;
        run(15'h7FFF, {12'h000, 12'hFFF}, 0, 0, 1'b0, 0, 0, 12);
        chk("cnt_after_first", int'(frame_cnt), 1);
        for (int i = 0; i < 20; i++) smp[i] = -1;
        run(15'h7FFF, {12'h000, 12'hFFF}, 0, 0, 1'b1, 0, 1, 12);
        for (int i = 0; i < 20; i++) smp[i] = (i % 5 == 4) ? 0 : ((i % 2 != 0) ? -1 : 1);
        run(15'h541F, {12'h000, 12'hFFF}, 0, 1, 1'b0, 0, 0, 10);
        for (int i = 0; i < 20; i++) smp[i] = 32767;
        run(15'h7FFF, {12'hF0F, 12'h0F0}, 0, 0, 1'b0, 0, 1, 8);
        chk("max_sum_no_wrap", last_max_sum, 163835);
        for (int i = 0; i < 20; i++) smp[i] = 1;
        run(15'h7FFF, {12'hABC, 12'hABC}, 1, 5, 1'b0, 0, 1, 7);
        run(15'h7FFF, {12'hABC, 12'hABC}, 0, 0, 1'b0, 0, 0, 7);
        run(15'h7FFF, {12'h000, 12'hFFF}, 0, 0, 1'b0, 5, -1, -1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("cnt_after_abort", int'(frame_cnt), 0);
        for (int i = 0; i < 20; i++) smp[i] = -1;
        run(15'h7FFF, {12'h000, 12'hFFF}, 0, 0, 1'b0, 0, 1, 12);
        chk("cnt_after_recover", int'(frame_cnt), 1);
        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/bnn_vad_core.md
BNN_VAD_CORE -- requirements
Module: bnn_vad_core

Interface
REQ-001 SHALL have parameter DW, default 16, meaning signed sample width.
REQ-002 SHALL have parameter FRAME_LEN, default 20, meaning samples per frame.
REQ-003 SHALL have parameter KSIZE, default 5, meaning conv window length.
REQ-004 SHALL have parameter STRIDE, default 5, meaning window step; N_WIN = (FRAME_LEN-KSIZE)/STRIDE+1, default 4.
REQ-005 SHALL have parameter N_CH, default 3, meaning conv channels.
REQ-006 SHALL have parameter N_CLS, default 2, meaning classes; CLSW = max(1,clog2(N_CLS)); SW = clog2(N_CH*N_WIN+1).
REQ-007 SHALL have port clk, input, 1 bit, meaning the single clock.
REQ-008 SHALL have port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-009 SHALL have port frame_vld, input, 1 bit, meaning the frame is offered.
REQ-010 SHALL have port frame_rdy, output, 1 bit, meaning the core can accept a frame.
REQ-011 SHALL have port frame_data, input, DW*FRAME_LEN bits, meaning samples, with sample i at bits [i*DW +: DW].
REQ-012 SHALL have port conv_w, input, N_CH*KSIZE bits, meaning conv weights; 1 = +1, 0 = -1; channel c tap k at bit c*KSIZE+k.
REQ-013 SHALL have port fc_w, input, N_CLS*N_CH*N_WIN bits, meaning binary classifier weights, with class j in slice j.
REQ-014 SHALL have port margin, input, SW bits, meaning the minimum winning lead.
REQ-015 SHALL have port result_vld, output, 1 bit, meaning a decision is valid.
REQ-016 SHALL have port result_rdy, input, 1 bit, meaning the consumer accepts the decision.
REQ-017 SHALL have port result, output, CLSW bits, meaning the class decision.
REQ-018 SHALL have port best_score, output, SW bits, meaning the winning score.
REQ-019 SHALL have port frame_cnt, output, 16 bits, meaning completed decisions, wrapping at 0xFFFF->0.

Function
REQ-020 SHALL use FSM states IDLE -> CONV -> FC -> CMP -> OUT -> IDLE.
REQ-021 SHALL drive frame_rdy=1 only in IDLE and SHALL latch frame_data on frame_vld&&frame_rdy (cycle 0).
REQ-022 In CONV, cycle w (1..N_WIN) SHALL compute, for all channels in parallel, sum over taps of ±sample[(w-1)*STRIDE+k] at width DW+clog2(KSIZE) with no overflow.
REQ-023 CONV SHALL store activation a[c][w] = 1 if sum >= 0, else 0 (sum=0 gives 1).
REQ-024 In FC, one class per cycle, score[j] = popcount(XNOR(a, fc_w slice j)), range 0..N_CH*N_WIN.
REQ-025 CMP SHALL pick the argmax class, with ties going to the lowest index.
REQ-026 CMP SHALL output that class if (best - second) >= margin; otherwise it SHALL output the previous result (hangover).
REQ-027 result_vld SHALL rise in cycle N_WIN+N_CLS+2 after acceptance (default 8) and SHALL hold result and best_score stable until result_rdy.
REQ-028 On result_vld&&result_rdy the core SHALL increment frame_cnt, return to IDLE and deassert result_vld next cycle; frame_rdy SHALL not rise before that cycle.
REQ-029 result and best_score SHALL keep their last values after the handshake.
REQ-030 conv_w, fc_w and margin SHALL be held stable by the user while frame_rdy=0; they are sampled live.
REQ-031 frame_vld outside IDLE SHALL be ignored.

Reset
REQ-032 While rst_n=0: state=IDLE, frame_rdy=1, result_vld=0, result=0, best_score=0, frame_cnt=0, activations cleared.
REQ-033 Reset mid-frame SHALL abort the frame with no result and no frame_cnt change; the previous hangover result is lost and becomes 0.

Structure
REQ-034 A shared package bnn_vad_pkg SHALL hold the state enum and the N_WIN/SW/CLSW derivation functions.
REQ-035 A sub-module popcount (parametrised input width, combinational) SHALL be instantiated for FC scoring.

Verification
REQ-036 All samples = 1, conv_w all 1, fc_w class0 all 1, class1 all 0, margin 0 -> result 0, best_score 12, result_vld at cycle 8, frame_cnt 1.
REQ-037 All samples = -1, conv_w all 1 (sums -5, activations 0), same fc_w -> result 1, best_score 12.
REQ-038 Samples alternating +1/-1 with window sum 0 -> all activations 1 (zero boundary); samples 0x7FFF with all-+1 weights -> sum 163835 with no wrap.
REQ-039 fc_w both classes identical, margin 1, previous result 1 -> result 1 (hangover); margin 0 -> result 0 (tie to the lowest index).
REQ-040 result_rdy held 0 for 5 cycles -> result_vld and result stable, frame_rdy=0, frame_cnt unchanged until the handshake.
REQ-041 rst_n pulsed in FC -> no result_vld, frame_cnt=0, frame_rdy=1 next cycle; a following frame completes normally.
